// File: rtl/ph_fifo.sv
// ph_fifo: parasite-to-host byte FIFO for tube register 3 block transfers.
//
// Generalises the two-byte register 3 FIFO to DEPTH entries with a
// programmable BLOCK size. In block mode the host sees data-available once
// a whole block is present, and that indication holds until the FIFO has
// fully drained. Single clock domain.
//
// Parameters:
//   DEPTH       entries, power of 2, >= 2
//   BLOCK       block-mode transfer size, 1..DEPTH
//   INIT_COUNT  entries considered valid after reset, 0..DEPTH
//   INIT_DATA   reset value of every storage entry
//
// Ports:
//   p_phi2           in   clock, all state on rising edge
//   h_rst            in   asynchronous reset, active-high
//   p_data           in   parasite write data
//   p_selectData     in   parasite data register selected
//   p_rdnw           in   parasite read/not-write
//   h_selectData     in   host data register selected
//   h_rd             in   host read strobe
//   one_byte_mode    in   1 = single-latch semantics, 0 = block mode
//   h_data           out  entry at read pointer (combinational)
//   h_data_available out  host may read (combinational)
//   p_empty          out  FIFO empty (combinational)
//   p_full           out  parasite must not write (combinational)
//   count            out  occupied entries, 0..DEPTH (combinational)
//
// Optional feature, enabled by defining PH_FIFO_OVERRUN_EN:
//   h_clr_err        in   clears both sticky error flags (wins over a set)
//   p_overrun        out  sticky: write attempted while FIFO held DEPTH entries
//   h_underrun       out  sticky: read attempted while FIFO was empty
// With the macro undefined these ports are absent and rejected operations
// leave no record.

module ph_fifo #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BLOCK      = 2,
  parameter int unsigned INIT_COUNT = 1,
  parameter logic [7:0]  INIT_DATA  = 8'haa
) (
  input  logic                      p_phi2,
  input  logic                      h_rst,
  input  logic [7:0]                p_data,
  input  logic                      p_selectData,
  input  logic                      p_rdnw,
  input  logic                      h_selectData,
  input  logic                      h_rd,
  input  logic                      one_byte_mode,
  output logic [7:0]                h_data,
  output logic                      h_data_available,
  output logic                      p_empty,
  output logic                      p_full,
  output logic [$clog2(DEPTH):0]    count
`ifdef PH_FIFO_OVERRUN_EN
  ,
  input  logic                      h_clr_err,
  output logic                      p_overrun,
  output logic                      h_underrun
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BLOCK_C = CW'(BLOCK);
  localparam logic [CW-1:0] INIT_C  = CW'(INIT_COUNT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } hold_state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [CW-1:0] waddr_q, waddr_d;
  logic [CW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] count_c;
  logic [CW-1:0] count_next_c;
  logic          is_full_c;
  logic          is_empty_c;
  logic          wr_try_c;
  logic          rd_try_c;
  logic          wr_acc_c;
  logic          rd_acc_c;
  logic          hold_c;
  hold_state_t   state_q, state_d;

  // Occupancy from the extra pointer bit; pointers wrap mod 2*DEPTH.
  assign count_c    = waddr_q - raddr_q;
  assign is_full_c  = (count_c == DEPTH_C);
  assign is_empty_c = (count_c == '0);

  // Acceptance is judged on the pre-edge count, so a read and write on the
  // same edge both go through unless the FIFO is at an extreme.
  assign wr_try_c = p_selectData & ~p_rdnw;
  assign rd_try_c = h_selectData & h_rd;
  assign wr_acc_c = wr_try_c & ~is_full_c;
  assign rd_acc_c = rd_try_c & ~is_empty_c;

  // Pointer next-state.
  always_comb begin
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    if (wr_acc_c) begin
      waddr_d = waddr_q + CW'(1);
    end
    if (rd_acc_c) begin
      raddr_d = raddr_q + CW'(1);
    end
  end

  assign count_next_c = waddr_d - raddr_d;

  // Pointer registers; reset makes INIT_COUNT entries appear valid.
  always_ff @(posedge p_phi2 or posedge h_rst) begin
    if (h_rst) begin
      waddr_q <= INIT_C;
      raddr_q <= '0;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
    end
  end

  // Storage; every entry returns to INIT_DATA on reset.
  always_ff @(posedge p_phi2 or posedge h_rst) begin
    if (h_rst) begin
      mem_q <= '{default: INIT_DATA};
    end else if (wr_acc_c) begin
      mem_q[waddr_q[AW-1:0]] <= p_data;
    end
  end

  // Hold FSM: state register.
  always_ff @(posedge p_phi2 or posedge h_rst) begin
    if (h_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold FSM: next state. Latches availability once seen so the host can
  // drain below BLOCK entries; single-byte mode keeps it parked in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (h_data_available && (count_next_c != '0)) begin
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (count_next_c == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (one_byte_mode) begin
      state_d = ST_IDLE;
    end
  end

  // Hold FSM: output.
  always_comb begin
    hold_c = 1'b0;
    if (state_q == ST_HELD) begin
      hold_c = 1'b1;
    end
  end

  // Flags. In block mode the parasite is held off until a whole block fits.
  always_comb begin
    p_full           = is_full_c;
    h_data_available = ~is_empty_c;
    if (!one_byte_mode) begin
      p_full           = ((DEPTH_C - count_c) < BLOCK_C);
      h_data_available = (count_c >= BLOCK_C) | hold_c;
    end
  end

  assign p_empty = is_empty_c;
  assign count   = count_c;
  assign h_data  = mem_q[raddr_q[AW-1:0]];

`ifdef PH_FIFO_OVERRUN_EN
  logic p_overrun_q;
  logic h_underrun_q;

  // Sticky error capture; a clear on the same edge as a new error wins.
  always_ff @(posedge p_phi2 or posedge h_rst) begin
    if (h_rst) begin
      p_overrun_q  <= 1'b0;
      h_underrun_q <= 1'b0;
    end else if (h_clr_err) begin
      p_overrun_q  <= 1'b0;
      h_underrun_q <= 1'b0;
    end else begin
      if (wr_try_c && is_full_c) begin
        p_overrun_q <= 1'b1;
      end
      if (rd_try_c && is_empty_c) begin
        h_underrun_q <= 1'b1;
      end
    end
  end

  assign p_overrun  = p_overrun_q;
  assign h_underrun = h_underrun_q;
`endif

endmodule
